// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction-fetch stage with a one-entry output buffer. It issues one
//   instruction-memory read at a time. It holds the returned word for the
//   decode stage until decode consumes it. It also redirects the PC on a
//   taken branch.
//
// Handshakes:
//   Memory side: imem_req/imem_addr are held stable until imem_valid is seen,
//   unless a redirect moves the PC. The memory returns exactly one imem_valid
//   pulse per accepted request, in order, with at most one request
//   outstanding. A response that belongs to a request abandoned by a redirect
//   is marked by the drop flag and is discarded when it arrives.
//   Decode side: a word transfers on a rising edge where if_valid=1 and
//   id_ready=1. A redirect in the same cycle wins, and the word is discarded.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  read request and word-aligned address (addr = pc)
//   imem_rdata/valid    read data, qualified by a one-cycle valid pulse
//   redirect/_target    taken branch and its target PC
//   id_ready            decode consumes if_instr this cycle
//   if_valid/if_instr   held instruction and its valid flag
//   if_opcode           if_instr[6:0]
//   if_pc/if_pc_plus4   PC of the held instruction and PC+4
//   misalign            one-cycle pulse after an accepted, unaligned redirect
//   dbg_state/dbg_drop  FSM state (0 IDLE, 1 REQ, 2 FULL) and drop flag
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [6:0]  if_opcode,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        misalign,
    output logic [1:0]  dbg_state,
    output logic        dbg_drop
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        drop, drop_nxt;
    logic        valid_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] ifpc_nxt;
    logic        misalign_nxt;
    logic [31:0] target_aligned;

    // Branch targets are forced onto a word boundary. The low bits only
    // feed the misalign flag.
    assign target_aligned = {redirect_target[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= 32'h0000_0000;
            if_pc    <= 32'h0000_0000;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            drop     <= drop_nxt;
            if_valid <= valid_nxt;
            if_instr <= instr_nxt;
            if_pc    <= ifpc_nxt;
            misalign <= misalign_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        drop_nxt     = drop;
        valid_nxt    = if_valid;
        instr_nxt    = if_instr;
        ifpc_nxt     = if_pc;
        misalign_nxt = 1'b0;
        imem_req     = 1'b0;

        case (state)
            IDLE: begin
                // Redirect is ignored here. The first request always uses
                // RESET_PC.
                state_nxt = REQ;
            end

            REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_nxt       = target_aligned;
                    valid_nxt    = 1'b0;
                    misalign_nxt = |redirect_target[1:0];
                    state_nxt    = REQ;
                    // If the response is still in flight, it must be thrown
                    // away when it lands. If it lands in this cycle, it is
                    // discarded now and nothing is left outstanding.
                    drop_nxt     = ~imem_valid;
                end else if (imem_valid) begin
                    if (drop) begin
                        drop_nxt = 1'b0;
                    end else begin
                        instr_nxt = imem_rdata;
                        ifpc_nxt  = pc;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = FULL;
                    end
                end
            end

            FULL: begin
                if (redirect) begin
                    pc_nxt       = target_aligned;
                    valid_nxt    = 1'b0;
                    misalign_nxt = |redirect_target[1:0];
                    state_nxt    = REQ;
                end else if (id_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = REQ;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign imem_addr   = pc;
    assign if_opcode   = if_instr[6:0];
    assign if_pc_plus4 = if_pc + 32'd4;
    assign dbg_state   = state;
    assign dbg_drop    = drop;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;

  // Main instance (RESET_PC = 0) and its memory model.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        misalign;
  logic [1:0]  dbg_state;
  logic        dbg_drop;

  // Second instance with RESET_PC at the top of the address space.
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2;
  logic        imem_valid2;
  logic        id_ready2;
  logic        if_valid2;
  logic [31:0] if_instr2;
  logic [6:0]  if_opcode2;
  logic [31:0] if_pc2;
  logic [31:0] if_pc_plus4_2;
  logic        misalign2;
  logic [1:0]  dbg_state2;
  logic        dbg_drop2;

  int tests_run = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] mon_dat;
  logic [6:0]  mon_op;

  logic        mem_busy;
  logic [1:0]  mem_cnt;
  logic [31:0] mem_addr;
  logic [1:0]  mem_lat;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .redirect(redirect), .redirect_target(redirect_target),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .misalign(misalign),
    .dbg_state(dbg_state), .dbg_drop(dbg_drop)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .imem_valid(imem_valid2),
    .redirect(1'b0), .redirect_target(32'h0000_0000),
    .id_ready(id_ready2),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_opcode(if_opcode2),
    .if_pc(if_pc2), .if_pc_plus4(if_pc_plus4_2), .misalign(misalign2),
    .dbg_state(dbg_state2), .dbg_drop(dbg_drop2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents: a fixed word at address 0, a distinct
  // pattern elsewhere.
  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  // Memory model: accepts one request when idle and answers mem_lat
  // cycles later with a single valid pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_busy   <= 1'b0;
      mem_cnt    <= 2'd0;
      mem_addr   <= 32'h0;
      imem_valid <= 1'b0;
      imem_rdata <= 32'h0;
    end else begin
      imem_valid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 2'd0) begin
          imem_valid <= 1'b1;
          imem_rdata <= mdata(mem_addr);
          mem_busy   <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 2'd1;
        end
      end else if (imem_req && !imem_valid) begin
        mem_busy <= 1'b1;
        mem_addr <= imem_addr;
        mem_cnt  <= mem_lat - 2'd1;
      end
    end
  end

  // Scoreboard: every word handed to decode must match the next expected PC.
  always @(negedge clk) begin
    if (rst_n && if_valid && id_ready && !redirect) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: consumed if_pc=%h, expected no consumption", if_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_dat = mdata(mon_exp);
        mon_op  = mon_dat[6:0];
        if (if_pc !== mon_exp || if_instr !== mon_dat ||
            if_pc_plus4 !== mon_exp + 32'd4 || if_opcode !== mon_op) begin
          fails++;
          $display("FAIL sb_consume: got pc=%h instr=%h pc4=%h op=%h, expected pc=%h instr=%h pc4=%h op=%h",
                   if_pc, if_instr, if_pc_plus4, if_opcode,
                   mon_exp, mon_dat, mon_exp + 32'd4, mon_op);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    id_ready = 1'b0;
    imem_valid2 = 1'b0;
    imem_rdata2 = 32'h0;
    id_ready2 = 1'b0;
    mem_lat = 2'd1;
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d expected words never delivered, expected 0", exp_q.size());
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Consumes every queued word with id_ready held high, within a cycle budget.
  task automatic drain(input int budget);
    int g;
    g = 0;
    id_ready = 1'b1;
    while (exp_q.size() != 0 && g < budget) begin
      tick();
      g++;
    end
    id_ready = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d words pending, expected 0", exp_q.size());
    end
  endtask

  task automatic wait_if_valid(input int budget);
    int g;
    g = 0;
    while (!if_valid && g < budget) begin
      tick();
      g++;
    end
    tests_run++;
    if (if_valid !== 1'b1) begin
      fails++;
      $display("FAIL wait_if_valid: if_valid=%b, expected 1", if_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b, expected 0", imem_req); end
    tests_run++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rst_if_valid: got %b, expected 0", if_valid); end
    tests_run++; if (if_instr !== 32'h0) begin fails++; $display("FAIL rst_if_instr: got %h, expected 0", if_instr); end
    tests_run++; if (if_pc !== 32'h0) begin fails++; $display("FAIL rst_if_pc: got %h, expected 0", if_pc); end
    tests_run++; if (misalign !== 1'b0) begin fails++; $display("FAIL rst_misalign: got %b, expected 0", misalign); end
    tests_run++; if (dbg_state !== S_IDLE || dbg_drop !== 1'b0) begin fails++; $display("FAIL rst_state: got state=%0d drop=%b, expected 0/0", dbg_state, dbg_drop); end
    tests_run++; if (imem_addr2 !== 32'hFFFF_FFFC) begin fails++; $display("FAIL rst_pc2: got %h, expected fffffffc", imem_addr2); end
    rst_n = 1'b1;
    #1;
    tests_run++; if (imem_req !== 1'b0) begin fails++; $display("FAIL idle_req: got %b, expected 0", imem_req); end
    tick();
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL first_req: got req=%b addr=%h, expected 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_first_fetch_and_stall();
    int g;
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    do_reset();
    mem_lat = 2'd1;
    g = 0;
    while (!imem_valid && g < 10) begin
      tick();
      g++;
    end
    tests_run++; if (imem_valid !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin fails++; $display("FAIL ff_resp: got valid=%b addr=%h if_valid=%b, expected 1/0/0", imem_valid, imem_addr, if_valid); end
    tick();
    tests_run++; if (if_valid !== 1'b1) begin fails++; $display("FAIL ff_latency: got if_valid=%b, expected 1", if_valid); end
    tests_run++; if (if_opcode !== 7'b0010011 || if_instr !== 32'h0050_0093) begin fails++; $display("FAIL ff_instr: got op=%b instr=%h, expected 0010011/00500093", if_opcode, if_instr); end
    tests_run++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h4) begin fails++; $display("FAIL ff_pc: got pc=%h pc4=%h, expected 0/4", if_pc, if_pc_plus4); end
    held_instr = 32'h0050_0093;
    held_pc = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (if_instr !== held_instr || if_pc !== held_pc || imem_req !== 1'b0 || if_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold: cycle %0d got instr=%h pc=%h req=%b v=%b, expected %h/%h/0/1", i, if_instr, if_pc, imem_req, if_valid, held_instr, held_pc);
      end
    end
    exp_q.push_back(32'h0);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || if_valid !== 1'b0) begin fails++; $display("FAIL stall_next: got req=%b addr=%h v=%b, expected 1/4/0", imem_req, imem_addr, if_valid); end
  endtask

  task automatic test_back_to_back();
    int g;
    do_reset();
    for (int i = 0; i < 12; i++) exp_q.push_back(32'(4 * i));
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      id_ready = 1'($urandom_range(0, 1));
      mem_lat = 2'($urandom_range(1, 3));
      tick();
      g++;
    end
    id_ready = 1'b0;
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_timeout: %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect_idle();
    do_reset();
    redirect = 1'b1;
    redirect_target = 32'h0000_0082;
    tick();
    redirect = 1'b0;
    tests_run++; if (imem_addr !== 32'h0 || dbg_state !== S_REQ) begin fails++; $display("FAIL rd_idle_addr: got addr=%h state=%0d, expected 0/1", imem_addr, dbg_state); end
    tests_run++; if (misalign !== 1'b0) begin fails++; $display("FAIL rd_idle_mis: got %b, expected 0", misalign); end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    mem_lat = 2'd2;
    tick();
    tick();
    tests_run++; if (dbg_state !== S_REQ || imem_valid !== 1'b0) begin fails++; $display("FAIL rp_pre: got state=%0d mvalid=%b, expected 1/0", dbg_state, imem_valid); end
    redirect = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    tests_run++; if (dbg_drop !== 1'b1 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin fails++; $display("FAIL rp_drop_set: got drop=%b addr=%h req=%b, expected 1/100/1", dbg_drop, imem_addr, imem_req); end
    tick();
    tests_run++; if (dbg_drop !== 1'b1 || if_valid !== 1'b0) begin fails++; $display("FAIL rp_stale_cycle: got drop=%b v=%b, expected 1/0", dbg_drop, if_valid); end
    tick();
    tests_run++; if (dbg_drop !== 1'b0 || if_valid !== 1'b0 || dbg_state !== S_REQ) begin fails++; $display("FAIL rp_discard: got drop=%b v=%b state=%0d, expected 0/0/1", dbg_drop, if_valid, dbg_state); end
    exp_q.push_back(32'h100);
    drain(20);
  endtask

  task automatic test_redirect_coincident();
    int g;
    do_reset();
    mem_lat = 2'd1;
    g = 0;
    while (!imem_valid && g < 10) begin
      tick();
      g++;
    end
    redirect = 1'b1;
    redirect_target = 32'h0000_0202;
    tick();
    redirect = 1'b0;
    tests_run++; if (if_valid !== 1'b0 || dbg_drop !== 1'b0) begin fails++; $display("FAIL rc_drop: got v=%b drop=%b, expected 0/0", if_valid, dbg_drop); end
    tests_run++; if (misalign !== 1'b1) begin fails++; $display("FAIL rc_mis: got %b, expected 1", misalign); end
    tests_run++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin fails++; $display("FAIL rc_addr: got addr=%h req=%b, expected 200/1", imem_addr, imem_req); end
    tick();
    tests_run++; if (misalign !== 1'b0) begin fails++; $display("FAIL rc_mis_pulse: got %b, expected 0", misalign); end
    exp_q.push_back(32'h200);
    drain(20);
  endtask

  task automatic test_redirect_full();
    do_reset();
    wait_if_valid(20);
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    id_ready = 1'b0;
    tests_run++; if (if_valid !== 1'b0 || imem_addr !== 32'h40 || dbg_state !== S_REQ) begin fails++; $display("FAIL rf_redirect: got v=%b addr=%h state=%0d, expected 0/40/1", if_valid, imem_addr, dbg_state); end
    tests_run++; if (dbg_drop !== 1'b0 || misalign !== 1'b0) begin fails++; $display("FAIL rf_flags: got drop=%b mis=%b, expected 0/0", dbg_drop, misalign); end
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    drain(30);
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    tests_run++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wr_req: got req=%b addr=%h, expected 1/fffffffc", imem_req2, imem_addr2); end
    imem_valid2 = 1'b1;
    imem_rdata2 = 32'h0000_0013;
    tick();
    imem_valid2 = 1'b0;
    tests_run++; if (if_valid2 !== 1'b1 || if_pc2 !== 32'hFFFF_FFFC || if_pc_plus4_2 !== 32'h0) begin fails++; $display("FAIL wr_capture: got v=%b pc=%h pc4=%h, expected 1/fffffffc/0", if_valid2, if_pc2, if_pc_plus4_2); end
    id_ready2 = 1'b1;
    tick();
    id_ready2 = 1'b0;
    tests_run++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0) begin fails++; $display("FAIL wr_next: got req=%b addr=%h, expected 1/0", imem_req2, imem_addr2); end
  endtask

  task automatic test_async_reset();
    do_reset();
    wait_if_valid(20);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || dbg_state !== S_IDLE) begin fails++; $display("FAIL ar_full: got v=%b req=%b state=%0d, expected 0/0/0", if_valid, imem_req, dbg_state); end
    do_reset();
    tick();
    tests_run++; if (imem_req !== 1'b1) begin fails++; $display("FAIL ar_req_pre: got %b, expected 1", imem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin fails++; $display("FAIL ar_req: got req=%b addr=%h, expected 0/0", imem_req, imem_addr); end
    do_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    id_ready = 1'b0;
    imem_valid2 = 1'b0;
    imem_rdata2 = 32'h0;
    id_ready2 = 1'b0;
    mem_lat = 2'd1;
    test_reset();
    test_first_fetch_and_stall();
    test_back_to_back();
    test_redirect_idle();
    test_redirect_pending();
    test_redirect_coincident();
    test_redirect_full();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL request an instruction read.
REQ-005 imem_addr  output  32  SHALL carry the read address, word-aligned.
REQ-006 imem_rdata  input  32  SHALL carry instruction data, valid only when imem_valid=1.
REQ-007 imem_valid  input  1  SHALL pulse for exactly one cycle per accepted request, in order, one outstanding maximum.
REQ-008 redirect  input  1  SHALL signal a taken branch (Branch AND Zero from the datapath).
REQ-009 redirect_target  input  32  SHALL carry the branch target PC.
REQ-010 id_ready  input  1  SHALL indicate the decode stage consumes if_instr this cycle.
REQ-011 if_valid  output  1  SHALL mark if_instr/if_pc as a live instruction.
REQ-012 if_instr  output  32  SHALL carry the held instruction word.
REQ-013 if_opcode  output  7  SHALL equal if_instr[6:0], the main decoder opcode input.
REQ-014 if_pc, if_pc_plus4  output  32 each  SHALL carry the instruction's PC and PC+4.
REQ-015 misalign  output  1  SHALL pulse one cycle when an accepted redirect_target[1:0] != 0.

Function
REQ-016 The block SHALL implement states IDLE, REQ, FULL plus a 1-bit drop flag and a 32-bit pc register.
REQ-017 IDLE: imem_req=0; next state unconditionally REQ.
REQ-018 REQ: imem_req=1, imem_addr=pc; imem_req and imem_addr SHALL stay stable until imem_valid unless redirected.
REQ-019 REQ with imem_valid=1, drop=0, redirect=0: capture imem_rdata and pc into output registers, if_valid=1 next cycle, pc<=pc+4, go to FULL.
REQ-020 REQ with imem_valid=1 and drop=1: discard data, clear drop, stay in REQ.
REQ-021 FULL: imem_req=0; outputs held stable; id_ready=1 clears if_valid next cycle, go to REQ.
REQ-022 Latency: imem_valid in cycle N -> if_valid=1 in cycle N+1; consumption in cycle M -> next imem_req=1 in cycle M+1.
REQ-023 Redirect in any state except IDLE: pc<=redirect_target with bits [1:0] forced to 0, if_valid<=0, next state REQ; redirect SHALL take priority over id_ready and imem_valid.
REQ-024 Redirect in REQ while imem_valid=0: set drop=1, so the stale in-flight response is discarded.
REQ-025 Redirect in REQ coinciding with imem_valid=1: discard the data, drop stays 0.
REQ-026 Redirect in FULL: held instruction discarded, drop unchanged (0).
REQ-027 Redirect in IDLE SHALL be ignored.
REQ-028 pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-029 if_pc_plus4 SHALL be if_pc+4 modulo 2^32, combinational from if_pc.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, drop=0, if_valid=0, if_instr=0, if_pc=0, misalign=0, imem_req=0.
REQ-031 Reset mid-request SHALL abandon the request; the bench memory is reset together with the block.
REQ-032 First imem_req=1 SHALL occur in the second rising edge after rst_n deasserts (IDLE then REQ).

Verification
REQ-033 Reset release, memory answers 1 cycle later with 32'h00500093 -> imem_addr=0, if_valid=1, if_opcode=7'b0010011, if_pc=0, if_pc_plus4=4.
REQ-034 id_ready=0 for 5 cycles in FULL -> if_instr/if_pc stable, imem_req=0; id_ready=1 -> next request at addr 4.
REQ-035 Redirect to 32'h100 while REQ pending, stale imem_valid 2 cycles later -> stale data discarded, next captured if_pc=32'h100.
REQ-036 Redirect to 32'h202 coincident with imem_valid -> data dropped, misalign pulse, imem_addr=32'h200, drop=0.
REQ-037 RESET_PC=32'hFFFF_FFFC, one fetch consumed -> next imem_addr=0, if_pc_plus4 of first instruction=0.
REQ-038 rst_n asserted while in FULL -> if_valid=0 and imem_req=0 in the same cycle, without waiting for a clock edge.
